salamander_sram_dma: RTL and testbench



---
 rtl/salamander_dma_pkg.sv | 16 +
 rtl/salamander_sram_dma.sv | 134 +++++++++++++
 tb/tb_salamander_sram_dma.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/salamander_dma_pkg.sv
// Shared types for the SRAM block-copy / fill engine.
// Holds the FSM state encoding and the transfer mode constants.
package salamander_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/salamander_sram_dma.sv
// SRAM bus initiator: copies a block of words between regions or fills a region with a constant.
// Copy costs 3 cycles per word (read, capture, write); fill costs 1 cycle per word. All outputs registered.
module salamander_sram_dma
    import salamander_dma_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_START,
    input  logic          i_MODE,
    input  logic [AW-1:0] i_SRC,
    input  logic [AW-1:0] i_DST,
    input  logic [AW:0]   i_LEN,
    input  logic [DW-1:0] i_FILL,
    output logic [AW-1:0] o_ADDR,
    output logic [DW-1:0] o_WDATA,
    input  logic [DW-1:0] i_RDATA,
    output logic          o_RD,
    output logic          o_WR,
    output logic          o_BUSY,
    output logic          o_DONE
);

    localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

    dma_state_t    r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_rd;
    logic          r_wr;
    logic          r_busy;
    logic          r_done;
    logic [AW:0]   r_idx;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic          r_mode;
    logic [DW-1:0] r_fill;

    logic [AW:0]   w_idx_nxt;

    // Index is one bit wider than the address so LEN = 2^AW terminates cleanly.
    assign w_idx_nxt = r_idx + IDX_ONE;

    assign o_ADDR  = r_addr;
    assign o_WDATA = r_wdata;
    assign o_RD    = r_rd;
    assign o_WR    = r_wr;
    assign o_BUSY  = r_busy;
    assign o_DONE  = r_done;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_mode  <= MODE_COPY;
            r_fill  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_START) begin
                        r_src  <= i_SRC;
                        r_dst  <= i_DST;
                        r_len  <= i_LEN;
                        r_mode <= i_MODE;
                        r_fill <= i_FILL;
                        r_idx  <= '0;
                        if (i_LEN == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (i_MODE == MODE_COPY) begin
                            r_state <= ST_READ;
                            r_rd    <= 1'b1;
                            r_addr  <= i_SRC;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_addr  <= i_DST;
                            r_wdata <= i_FILL;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_rd    <= 1'b0;
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_wdata <= i_RDATA;
                    r_addr  <= r_dst + r_idx[AW-1:0];
                    r_wr    <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_idx <= w_idx_nxt;
                    if (w_idx_nxt == r_len) begin
                        r_state <= ST_DONE;
                        r_wr    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_mode == MODE_COPY) begin
                        r_state <= ST_READ;
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_addr  <= r_src + w_idx_nxt[AW-1:0];
                    end else begin
                        r_addr  <= r_dst + w_idx_nxt[AW-1:0];
                        r_wdata <= r_fill;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_salamander_sram_dma.sv
// Directed bench for salamander_sram_dma with a behavioural single-port SRAM as the target memory.
module tb_salamander_sram_dma;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rd;
    logic          wr;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks;
    int n_errors;
    int busy_cnt;
    int done_cnt;
    int strobe_cnt;
    int clash_cnt;
    bit ok;

    salamander_sram_dma #(.AW(AW), .DW(DW)) dut (
        .i_MCLK  (clk),
        .i_RST_n (rst_n),
        .i_START (start),
        .i_MODE  (mode),
        .i_SRC   (src),
        .i_DST   (dst),
        .i_LEN   (len),
        .i_FILL  (fill),
        .o_ADDR  (addr),
        .o_WDATA (wdata),
        .i_RDATA (rdata),
        .o_RD    (rd),
        .o_WR    (wr),
        .o_BUSY  (busy),
        .o_DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: write at the strobed edge, read data valid after the strobed edge.
    always @(posedge clk) begin
        if (wr) mem[addr] <= wdata;
        if (rd) rdata <= mem[addr];
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (rd || wr) strobe_cnt++;
        if (rd && wr) clash_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon;
        busy_cnt   = 0;
        done_cnt   = 0;
        strobe_cnt = 0;
        clash_cnt  = 0;
    endtask

    task automatic start_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] l, input logic [DW-1:0] f);
        start = 1'b1;
        mode  = m;
        src   = s;
        dst   = d;
        len   = l;
        fill  = f;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        fill  = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        clr_mon();
        tick();
        tick();

        chk("rst_addr",  32'(addr),  32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_rd",    32'(rd),    32'h0);
        chk("rst_wr",    32'(wr),    32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_done",  32'(done),  32'h0);
        rst_n = 1'b1;
        tick();

        // Basic 4-word copy
        mem[10'h010] = 8'hA1; mem[10'h011] = 8'hB2; mem[10'h012] = 8'hC3; mem[10'h013] = 8'hD4;
        clr_mon();
        start_op(1'b0, 10'h010, 10'h040, 11'd4, 8'h00);
        chk("copy_first_rd",   32'(rd),   32'h1);
        chk("copy_first_addr", 32'(addr), 32'h010);
        chk("copy_first_busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("copy_first_wr",    32'(wr),    32'h1);
        chk("copy_first_waddr", 32'(addr),  32'h040);
        chk("copy_first_wdata", 32'(wdata), 32'hA1);
        wait_done("copy_done_seen");
        chk("copy_busy_cycles", 32'(busy_cnt),  32'd12);
        chk("copy_done_pulses", 32'(done_cnt),  32'd1);
        chk("copy_rd_wr_clash", 32'(clash_cnt), 32'd0);
        chk("copy_m40", 32'(mem[10'h040]), 32'hA1);
        chk("copy_m41", 32'(mem[10'h041]), 32'hB2);
        chk("copy_m42", 32'(mem[10'h042]), 32'hC3);
        chk("copy_m43", 32'(mem[10'h043]), 32'hD4);

        // Fill across the top of the address space
        mem[10'h002] = 8'h33;
        clr_mon();
        start_op(1'b1, 10'h000, 10'h3FE, 11'd4, 8'h5A);
        chk("fill_first_addr", 32'(addr), 32'h3FE);
        wait_done("fill_done_seen");
        chk("fill_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("fill_m3fe", 32'(mem[10'h3FE]), 32'h5A);
        chk("fill_m3ff", 32'(mem[10'h3FF]), 32'h5A);
        chk("fill_m000", 32'(mem[10'h000]), 32'h5A);
        chk("fill_m001", 32'(mem[10'h001]), 32'h5A);
        chk("fill_m002", 32'(mem[10'h002]), 32'h33);

        // Zero length: immediate completion, no bus traffic
        clr_mon();
        start_op(1'b0, 10'h010, 10'h080, 11'd0, 8'h00);
        chk("zero_done_now", 32'(done), 32'h1);
        chk("zero_busy_now", 32'(busy), 32'h0);
        tick();
        chk("zero_done_gone", 32'(done),       32'h0);
        chk("zero_busy_cnt",  32'(busy_cnt),   32'd0);
        chk("zero_strobes",   32'(strobe_cnt), 32'd0);
        chk("zero_done_cnt",  32'(done_cnt),   32'd1);

        // Forward overlap replicates the first word
        mem[10'h010] = 8'h77; mem[10'h011] = 8'h00; mem[10'h012] = 8'h00; mem[10'h013] = 8'h00;
        start_op(1'b0, 10'h010, 10'h011, 11'd3, 8'h00);
        wait_done("ovl_done_seen");
        chk("ovl_m11", 32'(mem[10'h011]), 32'h77);
        chk("ovl_m12", 32'(mem[10'h012]), 32'h77);
        chk("ovl_m13", 32'(mem[10'h013]), 32'h77);

        // A second START while busy is ignored
        mem[10'h020] = 8'h11; mem[10'h021] = 8'h22;
        clr_mon();
        start_op(1'b0, 10'h020, 10'h050, 11'd2, 8'h00);
        tick();
        start_op(1'b0, 10'h020, 10'h060, 11'd2, 8'h00);
        wait_done("busy_done_seen");
        tick();
        tick();
        chk("busy_idle_after", 32'(busy),         32'h0);
        chk("busy_done_cnt",   32'(done_cnt),     32'd1);
        chk("busy_m50",        32'(mem[10'h050]), 32'h11);
        chk("busy_m51",        32'(mem[10'h051]), 32'h22);
        chk("busy_m60",        32'(mem[10'h060]), 32'h00);
        chk("busy_m61",        32'(mem[10'h061]), 32'h00);

        // START held through the DONE cycle does not retrigger
        start = 1'b1; mode = 1'b1; dst = 10'h100; len = 11'd1; fill = 8'hEE;
        tick();
        tick();
        chk("hold_done", 32'(done), 32'h1);
        tick();
        start = 1'b0;
        chk("hold_no_busy", 32'(busy), 32'h0);
        chk("hold_no_wr",   32'(wr),   32'h0);
        tick();
        chk("hold_still_idle", 32'(busy),         32'h0);
        chk("hold_m100",       32'(mem[10'h100]), 32'hEE);

        // Reset during CAPT of word 2 aborts the copy
        mem[10'h030] = 8'h31; mem[10'h031] = 8'h32; mem[10'h032] = 8'h33; mem[10'h033] = 8'h34;
        clr_mon();
        start_op(1'b0, 10'h030, 10'h070, 11'd4, 8'h00);
        for (int i = 0; i < 7; i++) tick();
        chk("abort_in_capt", 32'({rd, wr, busy}), 32'b001);
        rst_n = 1'b0;
        #1;
        chk("abort_addr",  32'(addr),  32'h0);
        chk("abort_wdata", 32'(wdata), 32'h0);
        chk("abort_rdwr",  32'({rd, wr}), 32'h0);
        chk("abort_busy",  32'(busy),  32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("abort_no_done", 32'(done_cnt),     32'd0);
        chk("abort_m70",     32'(mem[10'h070]), 32'h31);
        chk("abort_m71",     32'(mem[10'h071]), 32'h32);
        chk("abort_m72",     32'(mem[10'h072]), 32'h00);
        chk("abort_m73",     32'(mem[10'h073]), 32'h00);
        clr_mon();
        start_op(1'b0, 10'h030, 10'h070, 11'd4, 8'h00);
        wait_done("restart_done_seen");
        chk("restart_busy_cycles", 32'(busy_cnt),     32'd12);
        chk("restart_m72",         32'(mem[10'h072]), 32'h33);
        chk("restart_m73",         32'(mem[10'h073]), 32'h34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
